ro_freq_meter: RTL
==================

Name: ro_freq_meter

Overview:
- Characterisation block that measures ring oscillators built from the mcu7t3v3 inverter, nand and buffer cells.
- The oscillators are the upstream producers. This block enables one of them, samples its output in the CLK domain, and counts rising edges over a programmable gate window.
- The result feeds the on-chip test register bank and gives a per-cell-type delay estimate on silicon.
- Each oscillator must include its own divider so that the RO_IN frequency is at most CLK/4.

Parameters:
- NUM_RO, 4: number of oscillator inputs.
- SEL_W, 2: width of SEL. Must satisfy 2^SEL_W >= NUM_RO.
- CNT_W, 16: width of the edge counter and COUNT.
- GATE_W, 16: width of GATE_LEN.
- SETTLE, 8: CLK cycles the oscillator runs enabled before counting starts (1..255).

Ports:
- CLK, input, 1: system clock. Everything is clocked on the rising edge.
- RST_N, input, 1: asynchronous active-low reset.
- RO_IN, input, NUM_RO: raw oscillator outputs. Asynchronous to CLK.
- SEL, input, SEL_W: index of the oscillator to measure. Sampled at START.
- GATE_LEN, input, GATE_W: measurement window in CLK cycles. Sampled at START.
- START, input, 1: begins a measurement. Only honoured in IDLE.
- RO_EN, output, NUM_RO: one-hot enable to the oscillators.
- BUSY, output, 1: high while a measurement is in progress.
- DONE, output, 1: one-cycle pulse when COUNT is updated.
- COUNT, output, CNT_W: rising-edge count from the last completed measurement.
- OVF, output, 1: the last measurement saturated.

Behaviour:
- Reset (RST_N low, asynchronous):
  - FSM goes to IDLE.
  - RO_EN, BUSY, DONE, COUNT and OVF are all 0.
  - Synchronizer, edge-detect, settle, gate and accumulator registers are all 0.
  - Reset asserted mid-measurement aborts it with no DONE. Outputs go to 0 immediately, not on the next edge.
- Synchronizer:
  - All NUM_RO inputs pass through a mux selected by the latched SEL.
  - The mux output feeds a 2-flop synchronizer, then a third flop for edge detection.
  - rise = s2 & ~s3. The synchronizer runs in every state.
  - A rising edge on RO_IN reaches rise 2-3 cycles later.
- FSM states: IDLE, SETTLE_ST, MEASURE, FINISH.
- IDLE:
  - START=1 latches SEL and GATE_LEN, clears the accumulator and OVF_int, and moves to SETTLE_ST.
  - START in any other state is ignored. It is not queued.
- SETTLE_ST:
  - RO_EN = 1 << SEL_latched. If SEL_latched >= NUM_RO, RO_EN = 0 (the result will be 0).
  - Stays exactly SETTLE cycles; edges are not counted.
  - Next state is MEASURE if GATE_LEN_latched != 0, otherwise FINISH.
- MEASURE:
  - RO_EN as in SETTLE_ST.
  - Stays exactly GATE_LEN_latched cycles, then moves to FINISH.
  - Each cycle with rise=1 increments the accumulator.
  - At 2^CNT_W-1 the accumulator holds (saturates) and OVF_int is set.
- FINISH (1 cycle):
  - RO_EN = 0.
  - COUNT <= accumulator and OVF <= OVF_int, both visible the following cycle together with DONE=1.
  - Returns to IDLE.
- BUSY is high in SETTLE_ST, MEASURE and FINISH. It is low in IDLE and on the DONE cycle.
- DONE is registered: high exactly one cycle, the cycle after FINISH.
- COUNT and OVF hold between DONE pulses. A new START does not clear them.
- Timing: with START sampled at edge 0, DONE is high in cycle SETTLE+GATE_LEN+2.
- A START on the same cycle as DONE is accepted (the FSM is already in IDLE).
- A back-to-back START gives a new measurement with no dead cycle beyond FINISH.
- SEL and GATE_LEN changing while BUSY have no effect.

Test Plan:
1. SEL=1, GATE_LEN=64, RO_IN[1] square wave with period 8 CLK, START pulse -> RO_EN=4'b0010 during SETTLE_ST and MEASURE. DONE at cycle 74 (8+64+2), COUNT=8 (±1 for phase), OVF=0, BUSY low on the DONE cycle.
2. GATE_LEN=0, START -> MEASURE skipped, DONE at cycle 10 (8+0+2), COUNT=0, OVF=0.
3. CNT_W=4 override, RO period 4, GATE_LEN=100 -> COUNT=15, OVF=1. Next run with GATE_LEN=8 -> COUNT=2, OVF=0.
4. START repeated every cycle while BUSY, and SEL changed to 3 mid-run -> exactly one DONE per accepted START. RO_EN stays 4'b0010 throughout. COUNT matches scenario 1.
5. RST_N pulled low for 1 cycle mid-MEASURE -> RO_EN, BUSY, COUNT and OVF are 0 immediately, with no DONE. A subsequent START completes normally.
6. SEL=2, RO_IN[2] period 6 and RO_IN[0] period 4, GATE_LEN=60 -> RO_EN=4'b0100, COUNT=10 (±1). RO_IN[0] activity does not affect the result.

Source files
------------

// File: rtl/ro_freq_meter.sv
// ro_freq_meter
// Ring-oscillator frequency meter. Enables one oscillator, brings its output
// into the CLK domain and counts rising edges over a programmable gate window.
//
// Ports:
//   CLK       in   system clock, rising edge
//   RST_N     in   asynchronous active-low reset
//   RO_IN     in   [NUM_RO]  raw oscillator outputs (asynchronous to CLK)
//   SEL       in   [SEL_W]   oscillator index, sampled on an accepted START
//   GATE_LEN  in   [GATE_W]  gate window in CLK cycles, sampled on an accepted START
//   START     in   request a measurement
//   RO_EN     out  [NUM_RO]  one-hot oscillator enable
//   BUSY      out  measurement in progress
//   DONE      out  one-cycle pulse, COUNT/OVF updated
//   COUNT     out  [CNT_W]   rising-edge count of the last completed measurement
//   OVF       out  last measurement saturated
//   dbg_state out  [2]       current FSM state (IDLE=0, SETTLE_ST=1, MEASURE=2, FINISH=3)
//
// Handshake: START is a request qualified only by the FSM being in IDLE
// (BUSY low); START while BUSY is dropped, never queued. Completion is the
// single-cycle DONE pulse, on which BUSY is already low, so a START presented
// in the DONE cycle is accepted.
module ro_freq_meter #(
  parameter int NUM_RO = 4,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 16,
  parameter int GATE_W = 16,
  parameter int SETTLE = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [NUM_RO-1:0] RO_IN,
  input  logic [SEL_W-1:0]  SEL,
  input  logic [GATE_W-1:0] GATE_LEN,
  input  logic              START,
  output logic [NUM_RO-1:0] RO_EN,
  output logic              BUSY,
  output logic              DONE,
  output logic [CNT_W-1:0]  COUNT,
  output logic              OVF,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SETTLE_ST = 2'd1,
    MEASURE   = 2'd2,
    FINISH    = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [GATE_W-1:0]   gate_len_q, gate_len_d;
  logic [7:0]          settle_cnt_q, settle_cnt_d;
  logic [GATE_W-1:0]   gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0]    acc_q, acc_d;
  logic                ovf_int_q, ovf_int_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                ovf_q, ovf_d;
  logic                done_q, done_d;
  logic                s1_q, s1_d;
  logic                s2_q, s2_d;
  logic                s3_q, s3_d;

  logic                ro_mux;
  logic                rise;
  logic [NUM_RO-1:0]   ro_en_c;

  // Out-of-range select leaves the mux at 0, so such a run counts nothing.
  always_comb begin
    ro_mux = 1'b0;
    for (int i = 0; i < NUM_RO; i++) begin
      if (sel_q == SEL_W'(i)) ro_mux = RO_IN[i];
    end
  end

  always_comb begin
    ro_en_c = '0;
    if (state_q == SETTLE_ST || state_q == MEASURE) begin
      for (int i = 0; i < NUM_RO; i++) begin
        ro_en_c[i] = (sel_q == SEL_W'(i));
      end
    end
  end

  assign rise = s2_q & ~s3_q;

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    gate_len_d   = gate_len_q;
    settle_cnt_d = settle_cnt_q;
    gate_cnt_d   = gate_cnt_q;
    acc_d        = acc_q;
    ovf_int_d    = ovf_int_q;
    count_d      = count_q;
    ovf_d        = ovf_q;
    done_d       = 1'b0;
    // Two synchronizer flops plus an edge-detect flop, running in every state.
    s1_d         = ro_mux;
    s2_d         = s1_q;
    s3_d         = s2_q;

    unique case (state_q)
      IDLE: begin
        if (START) begin
          sel_d        = SEL;
          gate_len_d   = GATE_LEN;
          acc_d        = '0;
          ovf_int_d    = 1'b0;
          settle_cnt_d = '0;
          state_d      = SETTLE_ST;
        end
      end
      SETTLE_ST: begin
        if (settle_cnt_q == 8'(SETTLE - 1)) begin
          gate_cnt_d = '0;
          state_d    = (gate_len_q != '0) ? MEASURE : FINISH;
        end else begin
          settle_cnt_d = settle_cnt_q + 8'd1;
        end
      end
      MEASURE: begin
        if (rise) begin
          // Saturate: an edge arriving at full scale is flagged, not wrapped.
          if (acc_q == '1) ovf_int_d = 1'b1;
          else             acc_d     = acc_q + CNT_W'(1);
        end
        if (gate_cnt_q == gate_len_q - GATE_W'(1)) begin
          state_d = FINISH;
        end else begin
          gate_cnt_d = gate_cnt_q + GATE_W'(1);
        end
      end
      FINISH: begin
        count_d = acc_q;
        ovf_d   = ovf_int_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      gate_len_q   <= '0;
      settle_cnt_q <= '0;
      gate_cnt_q   <= '0;
      acc_q        <= '0;
      ovf_int_q    <= 1'b0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      done_q       <= 1'b0;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      gate_len_q   <= gate_len_d;
      settle_cnt_q <= settle_cnt_d;
      gate_cnt_q   <= gate_cnt_d;
      acc_q        <= acc_d;
      ovf_int_q    <= ovf_int_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
      done_q       <= done_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      s3_q         <= s3_d;
    end
  end

  // Enable and BUSY decode straight from the state register so that reset
  // clears them without waiting for a clock edge.
  assign RO_EN     = ro_en_c;
  assign BUSY      = (state_q != IDLE);
  assign DONE      = done_q;
  assign COUNT     = count_q;
  assign OVF       = ovf_q;
  assign dbg_state = state_q;

endmodule
